// File: rtl/keypad_sequencer.sv
// keypad_sequencer
// Front end of the calculator input path. Scans a 4x4 active-low matrix
// keypad one column at a time, debounces each press and release, encodes
// the key as 4*row+col and tracks the 2-bit entry state (A/OP/B/RES).
//
// Handshake: key_valid is a one-cycle valid strobe with no ready. While it
// is high, state/value carry a new accepted key. The consumer must capture
// the key in that cycle. state/value then hold until the next strobe.
module keypad_sequencer #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [1:0] state,
  output logic [3:0] value
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

  // Scan FSM encoding
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Entry state encoding, as reported on the state output
  localparam logic [1:0] ENT_A   = 2'b00;
  localparam logic [1:0] ENT_OP  = 2'b01;
  localparam logic [1:0] ENT_B   = 2'b10;
  localparam logic [1:0] ENT_RES = 2'b11;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [1:0]       fsm;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [1:0]       entry;
  logic [1:0]       entry_next;
  logic [1:0]       low_idx;
  logic [3:0]       key_code;
  logic             any_low;
  logic             all_high;
  logic             latched_high;
  logic             scan_sample;
  logic             go_emit;
  logic             key_digit;
  logic             key_equals;

  // Exactly one column is driven low; the column is held outside SCAN so the
  // latched key stays visible on its row while debouncing and releasing.
  assign col = ~(4'b0001 << col_idx);

  assign any_low      = ~&row_sync;
  assign all_high     = &row_sync;
  assign latched_high = row_sync[row_idx];
  assign scan_sample  = (fsm == ST_SCAN) && (div_cnt == DIV_LAST);
  assign go_emit      = (fsm == ST_DEBOUNCE) && !latched_high && (deb_cnt == DEB_LAST);
  assign key_code     = {row_idx, col_idx};
  assign key_digit    = (key_code < 4'd10);
  assign key_equals   = (key_code == 4'hF);

  // Two-flop synchroniser for the asynchronous, pulled-up row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Lowest-index low row wins when several keys share the scanned column
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) low_idx = 2'(i);
    end
  end

  // Entry state transition for the key being emitted
  always_comb begin
    entry_next = entry;
    case (entry)
      ENT_A: begin
        if (key_digit || key_equals) entry_next = ENT_A;
        else                         entry_next = ENT_OP;
      end
      ENT_OP: begin
        if (key_digit) entry_next = ENT_B;
        else           entry_next = ENT_OP;
      end
      ENT_B: begin
        if (key_equals) entry_next = ENT_RES;
        else            entry_next = ENT_B;
      end
      default: begin
        if (key_digit || key_equals) entry_next = ENT_A;
        else                         entry_next = ENT_OP;
      end
    endcase
  end

  // Scan / debounce / emit / release sequencing with its counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= ST_SCAN;
      div_cnt <= '0;
      deb_cnt <= '0;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
    end else begin
      case (fsm)
        ST_SCAN: begin
          if (scan_sample) begin
            div_cnt <= '0;
            if (any_low) begin
              row_idx <= low_idx;
              deb_cnt <= '0;
              fsm     <= ST_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (latched_high) begin
            // Glitch: rescan the same column from the start of its period
            deb_cnt <= '0;
            div_cnt <= '0;
            fsm     <= ST_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            fsm     <= ST_EMIT;
          end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        ST_EMIT: begin
          deb_cnt <= '0;
          fsm     <= ST_RELEASE;
        end
        default: begin
          // Any low row (the held key or a second one) restarts the count,
          // so nothing new is accepted until the whole pad is released.
          if (!all_high) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            fsm     <= ST_SCAN;
          end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
      endcase
    end
  end

  // Registered key outputs: loaded on entry to EMIT, strobe high only in EMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      state     <= 2'b00;
      value     <= 4'h0;
    end else begin
      key_valid <= go_emit;
      if (go_emit) begin
        state <= entry;
        value <= key_code;
      end
    end
  end

  // Entry state advances on the edge that ends the EMIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= ENT_A;
    end else if (fsm == ST_EMIT) begin
      entry <= entry_next;
    end
  end

endmodule

// File: tb/tb_keypad_sequencer.sv
// tb_keypad_sequencer
// Drives a modelled 4x4 keypad (a pressed key pulls its row low only while
// its column is driven) and checks strobes against an expected queue built
// from the entry-state rules.
module tb_keypad_sequencer;

  localparam int SD      = 4;
  localparam int DC      = 8;
  localparam int LAT_MIN = DC + 2;
  localparam int LAT_MAX = 2 + 4 * SD + DC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [1:0] state;
  logic [3:0] value;

  logic [15:0] pressed = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          press_cyc = 0;
  bit          lat_en = 1'b0;
  logic [5:0]  exp_q[$];
  logic [1:0]  model_entry = 2'b00;
  logic [5:0]  mon_e;
  int          mon_lat;

  keypad_sequencer #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .state     (state),
    .value     (value)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: row r is low when a pressed key (r,c) has column c driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  // Scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_valid === 1'b1) begin
      strobes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got state=%b value=%0d, required no strobe", state, value);
      end else begin
        mon_e = exp_q.pop_front();
        if ({state, value} !== mon_e) begin
          bad++;
          $display("FAIL strobe_data: got state=%b value=%0d, required state=%b value=%0d",
                   state, value, mon_e[5:4], mon_e[3:0]);
        end
        if (lat_en) begin
          total++;
          mon_lat = cyc - press_cyc;
          if (mon_lat < LAT_MIN || mon_lat > LAT_MAX) begin
            bad++;
            $display("FAIL latency: got %0d cycles, required %0d..%0d", mon_lat, LAT_MIN, LAT_MAX);
          end
        end
      end
    end
  end

  // Entry-state rules: digits 0-9, operators 10-14, equals 15
  function automatic logic [1:0] model_next(input logic [1:0] st, input int code);
    bit digit;
    bit eq;
    digit = (code < 10);
    eq    = (code == 15);
    if (st == 2'b00) return (digit || eq) ? 2'b00 : 2'b01;
    if (st == 2'b01) return digit ? 2'b10 : 2'b01;
    if (st == 2'b10) return eq ? 2'b11 : 2'b10;
    return (digit || eq) ? 2'b00 : 2'b01;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the first cycle of a period in which col equals target
  task automatic wait_col_start(input logic [3:0] target);
    logic [3:0] prev;
    int n;
    prev = col;
    n = 0;
    @(negedge clk);
    while (!(col === target && prev !== target) && n < 200) begin
      prev = col;
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL col_wait: got col=%b after 200 cycles, required %b", col, target);
    end
  endtask

  // Press one key, queue its expected strobe, release and let it settle
  task automatic press_key(input int r, input int c, input int hold, input int gap);
    int code;
    code = 4 * r + c;
    exp_q.push_back({model_entry, 4'(code)});
    model_entry = model_next(model_entry, code);
    press_cyc = cyc;
    pressed[code] = 1'b1;
    wait_cycles(hold);
    pressed[code] = 1'b0;
    wait_cycles(gap);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: got %0d strobes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    total += 4;
    if (col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b, required 1110", col); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", key_valid); end
    if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b, required 00", state); end
    if (value !== 4'h0) begin bad++; $display("FAIL reset_value: got %h, required 0", value); end
    rst_n = 1'b1;
    model_entry = 2'b00;
  endtask

  // Called on the release cycle: col must rotate 4 cycles per column
  task automatic test_idle();
    logic [3:0] exp_col;
    int s0;
    s0 = strobes;
    for (int j = 0; j < 100; j++) begin
      exp_col = 4'b1111;
      exp_col[(j / SD) % 4] = 1'b0;
      total++;
      if (col !== exp_col) begin
        bad++;
        $display("FAIL idle_col: cycle %0d got %b, required %b", j, col, exp_col);
      end
      @(negedge clk);
    end
    total++;
    if (strobes != s0) begin bad++; $display("FAIL idle_strobe: got %0d strobes, required 0", strobes - s0); end
  endtask

  task automatic test_single_press();
    int s0;
    s0 = strobes;
    lat_en = 1'b1;
    press_key(1, 2, 40, 30);
    check_drained("single");
    total += 3;
    if (strobes - s0 != 1) begin bad++; $display("FAIL single_count: got %0d, required 1", strobes - s0); end
    if (state !== 2'b00) begin bad++; $display("FAIL single_state_hold: got %b, required 00", state); end
    if (value !== 4'd6) begin bad++; $display("FAIL single_value_hold: got %0d, required 6", value); end
  endtask

  task automatic test_sequence();
    int codes[6];
    codes = '{3, 10, 7, 15, 15, 5};
    for (int i = 0; i < 6; i++) press_key(codes[i] / 4, codes[i] % 4, 36, 24);
    check_drained("sequence");
  endtask

  task automatic test_glitch();
    int run;
    int s0;
    s0 = strobes;
    wait_col_start(4'b1110);
    pressed[0] = 1'b1;
    run = 0;
    while (col === 4'b1110 && run < 100) begin
      run++;
      if (run == 6) pressed[0] = 1'b0;
      @(negedge clk);
    end
    pressed[0] = 1'b0;
    // Detect + short debounce + a fresh full period on column 0
    total += 2;
    if (run < 10 || run > 14) begin
      bad++;
      $display("FAIL glitch_col0_run: got %0d cycles, required 10..14", run);
    end
    if (col !== 4'b1101) begin bad++; $display("FAIL glitch_next_col: got %b, required 1101", col); end
    wait_cycles(40);
    total++;
    if (strobes != s0) begin bad++; $display("FAIL glitch_strobe: got %0d strobes, required 0", strobes - s0); end
  endtask

  task automatic test_same_column();
    exp_q.push_back({model_entry, 4'd7});
    model_entry = model_next(model_entry, 7);
    press_cyc = cyc;
    pressed[7] = 1'b1;
    pressed[15] = 1'b1;
    wait_cycles(40);
    pressed = '0;
    wait_cycles(30);
    check_drained("same_column");
  endtask

  task automatic test_held_second();
    int s0;
    s0 = strobes;
    exp_q.push_back({model_entry, 4'd9});
    model_entry = model_next(model_entry, 9);
    press_cyc = cyc;
    pressed[9] = 1'b1;
    wait_cycles(40);
    pressed[1] = 1'b1;
    wait_cycles(20);
    pressed[9] = 1'b0;
    wait_cycles(20);
    pressed[1] = 1'b0;
    wait_cycles(30);
    total++;
    if (strobes - s0 != 1) begin bad++; $display("FAIL held_second_count: got %0d, required 1", strobes - s0); end
    press_key(0, 1, 40, 30);
    total++;
    if (strobes - s0 != 2) begin bad++; $display("FAIL repress_count: got %0d, required 2", strobes - s0); end
    check_drained("held_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      press_key($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(32, 48), $urandom_range(22, 30));
    check_drained("random");
  endtask

  task automatic test_reset_mid();
    int s0;
    press_key(2, 3, 40, 30);
    s0 = strobes;
    wait_col_start(4'b1011);
    pressed[6] = 1'b1;
    wait_cycles(7);
    #1;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (col !== 4'b1110) begin bad++; $display("FAIL async_col: got %b, required 1110", col); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b, required 0", key_valid); end
    if (state !== 2'b00) begin bad++; $display("FAIL async_state: got %b, required 00", state); end
    if (value !== 4'h0) begin bad++; $display("FAIL async_value: got %h, required 0", value); end
    model_entry = 2'b00;
    pressed = '0;
    wait_cycles(3);
    rst_n = 1'b1;
    total++;
    if (col !== 4'b1110) begin bad++; $display("FAIL restart_col0: got %b, required 1110", col); end
    wait_cycles(SD);
    total++;
    if (col !== 4'b1101) begin bad++; $display("FAIL restart_col1: got %b, required 1101", col); end
    wait_cycles(60);
    total++;
    if (strobes != s0) begin bad++; $display("FAIL reset_mid_strobe: got %0d strobes, required 0", strobes - s0); end
    press_key(0, 1, 40, 30);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_press();
    test_sequence();
    test_glitch();
    test_same_column();
    test_held_second();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
